// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, ALU/LSB result capture, in-order retire and flush.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle writebacks to the qj/qk operand lookups.
module reorder_buffer #(
    parameter int ROB_SIZE_LOG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    issue_valid,
    input  logic [1:0]              issue_type,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_pred,
    output logic [ROB_SIZE_LOG-1:0] issue_tag,
    output logic                    rob_full,
    input  logic                    alu_valid,
    input  logic [ROB_SIZE_LOG-1:0] alu_tag,
    input  logic [31:0]             alu_value,
    input  logic                    alu_jump,
    input  logic [31:0]             alu_target,
    input  logic                    lsb_valid,
    input  logic [ROB_SIZE_LOG-1:0] lsb_tag,
    input  logic [31:0]             lsb_value,
    input  logic [ROB_SIZE_LOG-1:0] qj_tag,
    input  logic [ROB_SIZE_LOG-1:0] qk_tag,
    output logic                    qj_ready,
    output logic                    qk_ready,
    output logic [31:0]             qj_value,
    output logic [31:0]             qk_value,
    output logic                    commit_valid,
    output logic [4:0]              commit_reg,
    output logic [31:0]             commit_value,
    output logic [ROB_SIZE_LOG-1:0] commit_reorder,
    output logic                    store_commit,
    output logic [ROB_SIZE_LOG-1:0] store_tag,
    output logic                    jump_rst,
    output logic [31:0]             jump_pc
);

    localparam int DEPTH = 1 << ROB_SIZE_LOG;
    localparam logic [ROB_SIZE_LOG:0]   CNT_FULL = {1'b1, {ROB_SIZE_LOG{1'b0}}};
    localparam logic [ROB_SIZE_LOG:0]   CNT_ONE  = {{ROB_SIZE_LOG{1'b0}}, 1'b1};
    localparam logic [ROB_SIZE_LOG:0]   CNT_ZERO = {(ROB_SIZE_LOG+1){1'b0}};
    localparam logic [ROB_SIZE_LOG-1:0] TAG_ONE  = {{(ROB_SIZE_LOG-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_STORE  = 2'd2,
        T_JALR   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  rd;
        logic        pred;
        logic        jump;
        logic [31:0] value;
        logic [31:0] target;
    } entry_t;

    entry_t                  entry_q [DEPTH];
    entry_t                  entry_d [DEPTH];
    logic [ROB_SIZE_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_SIZE_LOG:0]   count_q, count_d;
    logic                    commit_valid_q, commit_valid_d;
    logic [4:0]              commit_reg_q, commit_reg_d;
    logic [31:0]             commit_value_q, commit_value_d;
    logic [ROB_SIZE_LOG-1:0] commit_reorder_q, commit_reorder_d;
    logic                    store_commit_q, store_commit_d;
    logic [ROB_SIZE_LOG-1:0] store_tag_q, store_tag_d;
    logic                    jump_rst_q, jump_rst_d;
    logic [31:0]             jump_pc_q, jump_pc_d;
    logic                    rob_full_s, retire_s, alloc_s;
    entry_t                  head_s;

    // A JALR always redirects; a branch redirects only when the prediction was wrong.
    function automatic logic redirect_f(input entry_t e);
        return (e.kind == T_JALR) || ((e.kind == T_BRANCH) && (e.jump != e.pred));
    endfunction

    assign rob_full_s     = (count_q == CNT_FULL);
    assign rob_full       = rob_full_s;
    assign issue_tag      = tail_q;
    assign commit_valid   = commit_valid_q;
    assign commit_reg     = commit_reg_q;
    assign commit_value   = commit_value_q;
    assign commit_reorder = commit_reorder_q;
    assign store_commit   = store_commit_q;
    assign store_tag      = store_tag_q;
    assign jump_rst       = jump_rst_q;
    assign jump_pc        = jump_pc_q;

    // Next-state: retire/flush decision, writebacks, allocation and occupancy.
    always_comb begin
        entry_d          = entry_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        commit_valid_d   = 1'b0;
        store_commit_d   = 1'b0;
        jump_rst_d       = 1'b0;
        commit_reg_d     = commit_reg_q;
        commit_value_d   = commit_value_q;
        commit_reorder_d = commit_reorder_q;
        store_tag_d      = store_tag_q;
        jump_pc_d        = jump_pc_q;
        head_s           = entry_q[head_q];
        retire_s         = 1'b0;
        alloc_s          = 1'b0;
        if (rdy && !jump_rst_q) begin
            retire_s = (count_q != CNT_ZERO) && head_s.busy && head_s.ready;
            alloc_s  = issue_valid && !rob_full_s;
            if (retire_s) begin
                case (head_s.kind)
                    T_STORE: begin
                        store_commit_d = 1'b1;
                        store_tag_d    = head_q;
                    end
                    T_BRANCH: begin
                        commit_valid_d   = 1'b1;
                        commit_reg_d     = 5'd0;
                        commit_value_d   = head_s.value;
                        commit_reorder_d = head_q;
                    end
                    default: begin
                        commit_valid_d   = 1'b1;
                        commit_reg_d     = head_s.rd;
                        commit_value_d   = head_s.value;
                        commit_reorder_d = head_q;
                    end
                endcase
                if (redirect_f(head_s)) begin
                    jump_rst_d = 1'b1;
                    jump_pc_d  = head_s.target;
                end else begin
                    jump_pc_d  = jump_pc_q;
                end
            end else begin
                commit_valid_d = 1'b0;
            end

            // A redirecting retire discards every younger entry and this cycle's traffic.
            if (jump_rst_d) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entry_d[i] = '0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = CNT_ZERO;
            end else begin
                if (alu_valid && entry_q[alu_tag].busy) begin
                    entry_d[alu_tag].ready  = 1'b1;
                    entry_d[alu_tag].value  = alu_value;
                    entry_d[alu_tag].jump   = alu_jump;
                    entry_d[alu_tag].target = alu_target;
                end else begin
                    entry_d[alu_tag] = entry_d[alu_tag];
                end
                if (lsb_valid && entry_q[lsb_tag].busy) begin
                    entry_d[lsb_tag].ready = 1'b1;
                    entry_d[lsb_tag].value = lsb_value;
                end else begin
                    entry_d[lsb_tag] = entry_d[lsb_tag];
                end
                if (retire_s) begin
                    entry_d[head_q].busy  = 1'b0;
                    entry_d[head_q].ready = 1'b0;
                    head_d                = head_q + TAG_ONE;
                end else begin
                    head_d = head_q;
                end
                if (alloc_s) begin
                    entry_d[tail_q].busy   = 1'b1;
                    entry_d[tail_q].ready  = 1'b0;
                    entry_d[tail_q].kind   = rob_type_e'(issue_type);
                    entry_d[tail_q].rd     = issue_rd;
                    entry_d[tail_q].pred   = issue_pred;
                    entry_d[tail_q].jump   = 1'b0;
                    entry_d[tail_q].value  = 32'd0;
                    entry_d[tail_q].target = 32'd0;
                    tail_d                 = tail_q + TAG_ONE;
                end else begin
                    tail_d = tail_q;
                end
                case ({alloc_s, retire_s})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end else begin
            retire_s = 1'b0;
        end
    end

    // Operand lookup from registered entries, optionally forwarding same-cycle writebacks.
    always_comb begin
        qj_ready = entry_q[qj_tag].busy && entry_q[qj_tag].ready;
        qj_value = entry_q[qj_tag].value;
        qk_ready = entry_q[qk_tag].busy && entry_q[qk_tag].ready;
        qk_value = entry_q[qk_tag].value;
`ifdef ROB_CDB_BYPASS_EN
        if (rdy && !jump_rst_q && entry_q[qj_tag].busy) begin
            if (alu_valid && (alu_tag == qj_tag)) begin
                qj_ready = 1'b1;
                qj_value = alu_value;
            end else if (lsb_valid && (lsb_tag == qj_tag)) begin
                qj_ready = 1'b1;
                qj_value = lsb_value;
            end else begin
                qj_ready = entry_q[qj_tag].ready;
            end
        end else begin
            qj_value = entry_q[qj_tag].value;
        end
        if (rdy && !jump_rst_q && entry_q[qk_tag].busy) begin
            if (alu_valid && (alu_tag == qk_tag)) begin
                qk_ready = 1'b1;
                qk_value = alu_value;
            end else if (lsb_valid && (lsb_tag == qk_tag)) begin
                qk_ready = 1'b1;
                qk_value = lsb_value;
            end else begin
                qk_ready = entry_q[qk_tag].ready;
            end
        end else begin
            qk_value = entry_q[qk_tag].value;
        end
`else
        if (!rdy) begin
            qj_ready = entry_q[qj_tag].busy && entry_q[qj_tag].ready;
        end else begin
            qk_ready = entry_q[qk_tag].busy && entry_q[qk_tag].ready;
        end
`endif
    end

    // State and registered commit/flush outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= CNT_ZERO;
            commit_valid_q   <= 1'b0;
            commit_reg_q     <= 5'd0;
            commit_value_q   <= 32'd0;
            commit_reorder_q <= '0;
            store_commit_q   <= 1'b0;
            store_tag_q      <= '0;
            jump_rst_q       <= 1'b0;
            jump_pc_q        <= 32'd0;
        end else begin
            entry_q          <= entry_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            commit_valid_q   <= commit_valid_d;
            commit_reg_q     <= commit_reg_d;
            commit_value_q   <= commit_value_d;
            commit_reorder_q <= commit_reorder_d;
            store_commit_q   <= store_commit_d;
            store_tag_q      <= store_tag_d;
            jump_rst_q       <= jump_rst_d;
            jump_pc_q        <= jump_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed issue/writeback vectors, retire events checked in order.
module tb_reorder_buffer;

    localparam logic [1:0] REG = 2'd0, BRANCH = 2'd1, STORE = 2'd2, JALR = 2'd3;

    logic        clk, rst, rdy;
    logic        issue_valid, issue_pred;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic        alu_valid, alu_jump, lsb_valid;
    logic [3:0]  alu_tag, lsb_tag, qj_tag, qk_tag;
    logic [31:0] alu_value, alu_target, lsb_value;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_value, qk_value;
    logic        commit_valid, store_commit, jump_rst;
    logic [4:0]  commit_reg;
    logic [31:0] commit_value, jump_pc;
    logic [3:0]  commit_reorder, store_tag;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        cv;
        logic [4:0]  rg;
        logic [31:0] val;
        logic [3:0]  tag;
        logic        sc;
        logic        jr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e, mon_a;

    reorder_buffer #(.ROB_SIZE_LOG(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred(issue_pred), .issue_tag(issue_tag), .rob_full(rob_full),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value),
        .alu_jump(alu_jump), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
        .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_value(qj_value), .qk_value(qk_value),
        .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_value(commit_value),
        .commit_reorder(commit_reorder), .store_commit(store_commit), .store_tag(store_tag),
        .jump_rst(jump_rst), .jump_pc(jump_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic cv, input logic [4:0] rg, input logic [31:0] val,
                                input logic [3:0] tag, input logic sc, input logic jr,
                                input logic [31:0] pc);
        exp_t e;
        e.cv = cv; e.rg = rg; e.val = val; e.tag = tag; e.sc = sc; e.jr = jr; e.pc = pc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                         input logic [3:0] tag, input logic push, input exp_t e);
        chk("issue_tag_before_issue", {60'd0, issue_tag}, {60'd0, tag});
        if (push) sb.push_back(e);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred = pred;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wb(input logic av, input logic [3:0] at, input logic [31:0] aval,
                      input logic aj, input logic [31:0] atgt,
                      input logic lv, input logic [3:0] lt, input logic [31:0] lval);
        alu_valid = av; alu_tag = at; alu_value = aval; alu_jump = aj; alu_target = atgt;
        lsb_valid = lv; lsb_tag = lt; lsb_value = lval;
        step();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
    endtask

    // Retire monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (commit_valid || store_commit || jump_rst)) begin
            mon_a.cv  = commit_valid;
            mon_a.rg  = commit_valid ? commit_reg : 5'd0;
            mon_a.val = commit_valid ? commit_value : 32'd0;
            mon_a.tag = commit_valid ? commit_reorder : (store_commit ? store_tag : 4'd0);
            mon_a.sc  = store_commit;
            mon_a.jr  = jump_rst;
            mon_a.pc  = jump_rst ? jump_pc : 32'd0;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_retire: actual cv=%0d tag=%0d sc=%0d jr=%0d required no retire",
                         mon_a.cv, mon_a.tag, mon_a.sc, mon_a.jr);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL retire: actual cv=%0d reg=%0d val=%h tag=%0d sc=%0d jr=%0d pc=%h required cv=%0d reg=%0d val=%h tag=%0d sc=%0d jr=%0d pc=%h",
                             mon_a.cv, mon_a.rg, mon_a.val, mon_a.tag, mon_a.sc, mon_a.jr, mon_a.pc,
                             mon_e.cv, mon_e.rg, mon_e.val, mon_e.tag, mon_e.sc, mon_e.jr, mon_e.pc);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; rdy = 1'b1;
        issue_valid = 1'b0; issue_type = REG; issue_rd = 5'd0; issue_pred = 1'b0;
        alu_valid = 1'b0; alu_tag = 4'd0; alu_value = 32'd0; alu_jump = 1'b0; alu_target = 32'd0;
        lsb_valid = 1'b0; lsb_tag = 4'd0; lsb_value = 32'd0;
        qj_tag = 4'd0; qk_tag = 4'd0;
        #2;
        chk("reset_flags", {41'd0, commit_valid, store_commit, jump_rst, rob_full, qj_ready, qk_ready,
                            issue_tag, commit_reorder, store_tag, commit_reg}, 64'd0);
        chk("reset_values", {commit_value, jump_pc}, 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Single REG entry: commit pulse exactly one cycle after the writeback edge.
        issue(REG, 5'd5, 1'b0, 4'd0, 1'b1, mk(1'b1, 5'd5, 32'h1234, 4'd0, 1'b0, 1'b0, 32'd0));
        wb(1'b1, 4'd0, 32'h1234, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        @(negedge clk); chk("latency_after_wb_edge", {63'd0, commit_valid}, 64'd0);
        @(negedge clk); chk("latency_commit_pulse", {63'd0, commit_valid}, 64'd1);
        @(negedge clk); chk("latency_pulse_one_cycle", {63'd0, commit_valid}, 64'd0);

        // Out-of-order completion, both buses in one cycle, in-order retire back to back.
        issue(REG, 5'd1, 1'b0, 4'd1, 1'b1, mk(1'b1, 5'd1, 32'h11, 4'd1, 1'b0, 1'b0, 32'd0));
        issue(REG, 5'd2, 1'b0, 4'd2, 1'b1, mk(1'b1, 5'd2, 32'h22, 4'd2, 1'b0, 1'b0, 32'd0));
        issue(REG, 5'd3, 1'b0, 4'd3, 1'b1, mk(1'b1, 5'd3, 32'h33, 4'd3, 1'b0, 1'b0, 32'd0));
        wb(1'b1, 4'd3, 32'h33, 1'b0, 32'd0, 1'b1, 4'd2, 32'h22);
        wb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd1, 32'h11);
        @(negedge clk); chk("ooo_not_yet", {63'd0, commit_valid}, 64'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("ooo_consecutive_tag", {59'd0, commit_valid, commit_reorder}, {59'd1, i[3:0]});
        end

        // STORE retires through store_commit; operand lookup around its writeback.
        issue(STORE, 5'd0, 1'b0, 4'd4, 1'b1, mk(1'b0, 5'd0, 32'd0, 4'd4, 1'b1, 1'b0, 32'd0));
        qj_tag = 4'd4; qk_tag = 4'd4;
        #1;
        chk("qj_before_wb", {63'd0, qj_ready}, 64'd0);
        lsb_valid = 1'b1; lsb_tag = 4'd4; lsb_value = 32'hABC;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("qj_bypass_same_cycle", {31'd0, qj_ready, qj_value}, {31'd0, 1'b1, 32'hABC});
`else
        chk("qj_no_bypass_same_cycle", {63'd0, qj_ready}, 64'd0);
`endif
        step();
        lsb_valid = 1'b0;
        chk("qj_after_wb", {31'd0, qj_ready, qj_value}, {31'd0, 1'b1, 32'hABC});
        chk("qk_after_wb", {31'd0, qk_ready, qk_value}, {31'd0, 1'b1, 32'hABC});
        step();
        chk("store_commit_pulse", {58'd0, store_commit, commit_valid, store_tag}, {58'd0, 1'b1, 1'b0, 4'd4});
        step();

        // Mispredicted branch with four completed younger entries: flush, nothing younger retires.
        issue(BRANCH, 5'd0, 1'b0, 4'd5, 1'b1, mk(1'b1, 5'd0, 32'd0, 4'd5, 1'b0, 1'b1, 32'h100));
        for (int i = 6; i <= 9; i++) begin
            issue(REG, 5'(i + 4), 1'b0, i[3:0], 1'b0, mk(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0));
        end
        wb(1'b1, 4'd6, 32'h66, 1'b0, 32'd0, 1'b1, 4'd7, 32'h77);
        wb(1'b1, 4'd8, 32'h88, 1'b0, 32'd0, 1'b1, 4'd9, 32'h99);
        wb(1'b1, 4'd5, 32'd0, 1'b1, 32'h100, 1'b0, 4'd0, 32'd0);
        issue_valid = 1'b1; issue_type = REG; issue_rd = 5'd20;
        @(negedge clk); chk("flush_not_before_retire", {59'd0, jump_rst, issue_tag}, {59'd0, 1'b0, 4'd10});
        step();
        chk("flush_pulse", {31'd0, jump_rst, jump_pc}, {31'd0, 1'b1, 32'h100});
        chk("flush_clears_tail", {60'd0, issue_tag}, 64'd0);
        step();
        issue_valid = 1'b0;
        chk("flush_blocks_issue", {58'd0, jump_rst, rob_full, issue_tag}, 64'd0);
        repeat (3) step();

        // Correctly predicted branch commits quietly; JALR always redirects.
        issue(BRANCH, 5'd0, 1'b1, 4'd0, 1'b1, mk(1'b1, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0));
        issue(JALR, 5'd1, 1'b0, 4'd1, 1'b1, mk(1'b1, 5'd1, 32'h8, 4'd1, 1'b0, 1'b1, 32'h200));
        wb(1'b1, 4'd0, 32'd0, 1'b1, 32'h40, 1'b0, 4'd0, 32'd0);
        wb(1'b1, 4'd1, 32'h8, 1'b1, 32'h200, 1'b0, 4'd0, 32'd0);
        repeat (3) step();
        chk("jalr_flush_tail", {59'd0, rob_full, issue_tag}, 64'd0);

        // Fill all 16 entries; retire does not free space for a same-cycle issue; tail wraps.
        for (int i = 0; i < 16; i++) begin
            issue(REG, i[4:0], 1'b0, i[3:0], 1'b1,
                  mk(1'b1, i[4:0], 32'h1000 + i, i[3:0], 1'b0, 1'b0, 32'd0));
        end
        chk("full_after_16", {59'd0, rob_full, issue_tag}, {59'd1, 4'd0});
        issue_valid = 1'b1; issue_type = REG; issue_rd = 5'd31;
        alu_valid = 1'b1; alu_tag = 4'd0; alu_value = 32'h1000; alu_jump = 1'b0;
        step();
        alu_valid = 1'b0;
        chk("issue_dropped_when_full", {59'd0, rob_full, issue_tag}, {59'd1, 4'd0});
        step();
        issue_valid = 1'b0;
        chk("retire_frees_next_cycle", {59'd0, rob_full, issue_tag}, {59'd0, 4'd0});
        issue(REG, 5'd30, 1'b0, 4'd0, 1'b1, mk(1'b1, 5'd30, 32'h2000, 4'd0, 1'b0, 1'b0, 32'd0));
        chk("full_again_after_wrap", {59'd0, rob_full, issue_tag}, {59'd1, 4'd1});
        for (int i = 1; i < 16; i++) begin
            wb(1'b1, i[3:0], 32'h1000 + i, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        end
        wb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h2000);
        repeat (4) step();
        chk("drained", {59'd0, rob_full, issue_tag}, {59'd0, 4'd1});

        // rdy low freezes issue, writeback and retire.
        issue(REG, 5'd4, 1'b0, 4'd1, 1'b1, mk(1'b1, 5'd4, 32'h44, 4'd1, 1'b0, 1'b0, 32'd0));
        rdy = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_tag = 4'd1; alu_value = 32'h44;
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        qj_tag = 4'd1;
        #1;
        chk("freeze_issue_and_wb", {59'd0, qj_ready, issue_tag}, {59'd0, 4'd2});
        rdy = 1'b1;
        wb(1'b1, 4'd1, 32'h44, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        rdy = 1'b0;
        repeat (3) begin
            step();
            chk("freeze_no_retire", {63'd0, commit_valid}, 64'd0);
        end
        rdy = 1'b1;
        step();
        chk("retire_after_unfreeze", {58'd0, commit_valid, commit_reg}, {58'd1, 5'd4});
        step();

        // Asynchronous reset between edges with entries outstanding.
        for (int i = 2; i <= 4; i++) begin
            issue(REG, 5'd7, 1'b0, i[3:0], 1'b0, mk(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0));
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_flags", {41'd0, commit_valid, store_commit, jump_rst, rob_full, qj_ready, qk_ready,
                                  issue_tag, commit_reorder, store_tag, commit_reg}, 64'd0);
        chk("async_reset_values", {commit_value, jump_pc}, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("after_reset_tail", {60'd0, issue_tag}, 64'd0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
